// File: rtl/keypad_text_console.sv
// Keypad-driven text console: turns key codes into writes to a COLS x ROWS text memory.
// Define CONSOLE_SCROLL_EN to scroll on overflow; otherwise the cursor wraps to a blanked row 0.
module keypad_text_console #(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 30,
    parameter int unsigned ADDR_W = 12,
    parameter logic [7:0]  ATTR   = 8'h0F
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [7:0]                key_code,
    input  logic                      key_valid,
    output logic                      key_ready,
    output logic [ADDR_W-1:0]         vga_addr,
    output logic                      vga_we,
    output logic [15:0]               vga_data,
    input  logic [15:0]               vga_rd,
    output logic [$clog2(COLS)-1:0]   cur_col,
    output logic [$clog2(ROWS)-1:0]   cur_row,
    output logic                      busy
);

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);
    localparam logic [ADDR_W-1:0] CELLS_LAST = ADDR_W'(COLS * ROWS - 1);
    localparam logic [ADDR_W-1:0] LINE_LAST  = ADDR_W'(COLS - 1);
    localparam logic [CW-1:0]     COL_MAX    = CW'(COLS - 1);
    localparam logic [RW-1:0]     ROW_MAX    = RW'(ROWS - 1);
    localparam logic [7:0]        SPACE      = 8'h20;
`ifdef CONSOLE_SCROLL_EN
    localparam logic [ADDR_W-1:0] SCROLL_LAST = ADDR_W'(COLS * (ROWS - 1) - 1);
    localparam logic [ADDR_W-1:0] BLANK_BASE  = ADDR_W'(COLS * (ROWS - 1));
`else
    localparam logic [ADDR_W-1:0] BLANK_BASE  = '0;
    logic [15:0] unused_rd;
    assign unused_rd = vga_rd;
`endif

    typedef enum logic [2:0] {
        StIdle, StPut, StClear, StScrollRd, StScrollWr, StBlank
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [7:0]        char_q, char_d;
    logic              adv_q, adv_d;
    logic              row_adv;
    logic [ADDR_W-1:0] cur_addr;

    assign cur_addr = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
    assign cur_col  = col_q;
    assign cur_row  = row_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StClear;
            idx_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            char_q  <= SPACE;
            adv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            row_q   <= row_d;
            char_q  <= char_d;
            adv_q   <= adv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        col_d   = col_q;
        row_d   = row_q;
        char_d  = char_q;
        adv_d   = adv_q;
        row_adv = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (key_valid) begin
                    if (key_code >= 8'h20 && key_code <= 8'h7E) begin
                        char_d  = key_code;
                        adv_d   = 1'b1;
                        state_d = StPut;
                    end else if (key_code == 8'h0A) begin
                        row_adv = 1'b1;
                    end else if (key_code == 8'h08) begin
                        // Backspace moves first, then PUT blanks the new cursor cell.
                        if (col_q != '0) begin
                            col_d   = col_q - CW'(1);
                            char_d  = SPACE;
                            adv_d   = 1'b0;
                            state_d = StPut;
                        end else if (row_q != '0) begin
                            col_d   = COL_MAX;
                            row_d   = row_q - RW'(1);
                            char_d  = SPACE;
                            adv_d   = 1'b0;
                            state_d = StPut;
                        end
                    end else if (key_code == 8'h0C) begin
                        idx_d   = '0;
                        state_d = StClear;
                    end
                end
            end
            StPut: begin
                state_d = StIdle;
                if (adv_q) begin
                    if (col_q == COL_MAX) row_adv = 1'b1;
                    else                  col_d   = col_q + CW'(1);
                end
            end
            StClear: begin
                if (idx_q == CELLS_LAST) begin
                    idx_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
`ifdef CONSOLE_SCROLL_EN
            StScrollRd: state_d = StScrollWr;
            StScrollWr: begin
                if (idx_q == SCROLL_LAST) begin
                    idx_d   = '0;
                    state_d = StBlank;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = StScrollRd;
                end
            end
`endif
            StBlank: begin
                if (idx_q == LINE_LAST) begin
                    idx_d   = '0;
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (row_adv) begin
            col_d = '0;
            if (row_q == ROW_MAX) begin
                idx_d = '0;
`ifdef CONSOLE_SCROLL_EN
                row_d   = ROW_MAX;
                state_d = StScrollRd;
`else
                row_d   = '0;
                state_d = StBlank;
`endif
            end else begin
                row_d = row_q + RW'(1);
            end
        end
    end

    always_comb begin
        vga_we    = 1'b0;
        vga_addr  = '0;
        vga_data  = '0;
        key_ready = 1'b0;
        busy      = 1'b1;
        unique case (state_q)
            StIdle: begin
                key_ready = 1'b1;
                busy      = 1'b0;
            end
            StPut: begin
                vga_we   = 1'b1;
                vga_addr = cur_addr;
                vga_data = {ATTR, char_q};
            end
            StClear: begin
                vga_we   = 1'b1;
                vga_addr = idx_q;
                vga_data = {ATTR, SPACE};
            end
`ifdef CONSOLE_SCROLL_EN
            StScrollRd: vga_addr = idx_q + ADDR_W'(COLS);
            StScrollWr: begin
                vga_we   = 1'b1;
                vga_addr = idx_q;
                vga_data = vga_rd;
            end
`endif
            StBlank: begin
                vga_we   = 1'b1;
                vga_addr = BLANK_BASE + idx_q;
                vga_data = {ATTR, SPACE};
            end
            default: ;
        endcase
        // Reset is asynchronous, so outputs are forced quiet for its whole duration.
        if (rst) begin
            vga_we    = 1'b0;
            vga_addr  = '0;
            vga_data  = '0;
            key_ready = 1'b0;
            busy      = 1'b1;
        end
    end

endmodule

// File: tb/tb_keypad_text_console.sv
// Self-checking bench for keypad_text_console: random keys against a screen-level model.
module tb_keypad_text_console;

    localparam int C = 80;
    localparam int R = 30;
    localparam int N = C * R;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  key_code = 8'h00;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [11:0] vga_addr;
    logic        vga_we;
    logic [15:0] vga_data;
    logic [15:0] vga_rd;
    logic [6:0]  cur_col;
    logic [4:0]  cur_row;
    logic        busy;

    keypad_text_console #(
        .COLS(C), .ROWS(R), .ADDR_W(12), .ATTR(8'h0F)
    ) dut (
        .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
        .key_ready(key_ready), .vga_addr(vga_addr), .vga_we(vga_we), .vga_data(vga_data),
        .vga_rd(vga_rd), .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          addr;
        logic [15:0] data;
    } wr_t;

    wr_t         wq[$];
    logic [15:0] tmem [0:4095];
    int          cyc = 0;

    // Text memory with one-cycle read latency, plus a log of every write strobe.
    always @(posedge clk) begin
        cyc    <= cyc + 1;
        vga_rd <= tmem[vga_addr];
        if (vga_we) begin
            tmem[vga_addr] <= vga_data;
            wq.push_back('{cyc, int'(vga_addr), vga_data});
        end
    end

    logic [7:0] mscr [N];
    logic [7:0] old  [N];
    int mrow = 0;
    int mcol = 0;
    int tests = 0;
    int fails = 0;

    function automatic void model_row_adv();
        mcol = 0;
        if (mrow == R - 1) begin
`ifdef CONSOLE_SCROLL_EN
            for (int i = 0; i < N - C; i++) mscr[i] = mscr[i + C];
            for (int i = N - C; i < N; i++) mscr[i] = 8'h20;
            mrow = R - 1;
`else
            for (int i = 0; i < C; i++) mscr[i] = 8'h20;
            mrow = 0;
`endif
        end else begin
            mrow++;
        end
    endfunction

    function automatic void model_key(input logic [7:0] k);
        if (k >= 8'h20 && k <= 8'h7E) begin
            mscr[mrow * C + mcol] = k;
            if (mcol == C - 1) model_row_adv();
            else mcol++;
        end else if (k == 8'h0A) begin
            model_row_adv();
        end else if (k == 8'h08) begin
            if (mrow != 0 || mcol != 0) begin
                if (mcol == 0) begin
                    mcol = C - 1;
                    mrow--;
                end else begin
                    mcol--;
                end
                mscr[mrow * C + mcol] = 8'h20;
            end
        end else if (k == 8'h0C) begin
            for (int i = 0; i < N; i++) mscr[i] = 8'h20;
            mrow = 0;
            mcol = 0;
        end
    endfunction

    function automatic logic [7:0] rand_print();
        return 8'($urandom_range(32'h20, 32'h7E));
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (key_ready !== 1'b1 && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (key_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: key_ready=%b after %0d cycles, want 1", tag, key_ready, n);
        end
    endtask

    task automatic send_key(input logic [7:0] k, output int acc);
        wait_ready("pre_key");
        acc       = cyc;
        key_code  = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        wait_ready("post_key");
        model_key(k);
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (vga_we !== 1'b0) begin fails++; $display("FAIL rst_we: got %b want 0", vga_we); end
        tests++; if (vga_addr !== 12'd0) begin fails++; $display("FAIL rst_addr: got %0d want 0", vga_addr); end
        tests++; if (vga_data !== 16'h0) begin fails++; $display("FAIL rst_data: got %h want 0", vga_data); end
        tests++; if (cur_col !== 7'd0) begin fails++; $display("FAIL rst_col: got %0d want 0", cur_col); end
        tests++; if (cur_row !== 5'd0) begin fails++; $display("FAIL rst_row: got %0d want 0", cur_row); end
        tests++; if (key_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", key_ready); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_busy: got %b want 1", busy); end
        wq.delete();
        rst = 1'b0;
        @(negedge clk);
        wait_ready("clear");
        tests++; if (wq.size() != N) begin fails++; $display("FAIL clear_count: got %0d want %0d", wq.size(), N); end
        foreach (wq[i]) if (wq[i].addr != i || wq[i].data !== 16'h0F20) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL clear_order: %0d bad writes want 0", bad); end
        tests++; if (key_ready !== 1'b1) begin fails++; $display("FAIL clear_ready: got %b want 1", key_ready); end
        tests++; if (cur_col !== 7'd0 || cur_row !== 5'd0) begin
            fails++; $display("FAIL clear_cursor: got (%0d,%0d) want (0,0)", cur_row, cur_col);
        end
        model_key(8'h0C);
    endtask

    task automatic test_put();
        int acc;
        wq.delete();
        send_key(8'h41, acc);
        tests++; if (wq.size() != 1) begin fails++; $display("FAIL put_count: got %0d want 1", wq.size()); end
        if (wq.size() > 0) begin
            tests++; if (wq[0].addr != 0) begin fails++; $display("FAIL put_addr: got %0d want 0", wq[0].addr); end
            tests++; if (wq[0].data !== 16'h0F41) begin fails++; $display("FAIL put_data: got %h want 0f41", wq[0].data); end
            tests++; if (wq[0].cyc != acc + 1) begin
                fails++; $display("FAIL put_latency: write cycle %0d want %0d", wq[0].cyc, acc + 1);
            end
        end
        tests++; if (cur_col !== 7'd1 || cur_row !== 5'd0) begin
            fails++; $display("FAIL put_cursor: got (%0d,%0d) want (0,1)", cur_row, cur_col);
        end
    endtask

    task automatic test_wrap();
        int acc;
        send_key(8'h0A, acc);
        send_key(8'h0A, acc);
        for (int i = 0; i < 79; i++) send_key(rand_print(), acc);
        tests++; if (cur_row !== 5'd2 || cur_col !== 7'd79) begin
            fails++; $display("FAIL wrap_pre_cursor: got (%0d,%0d) want (2,79)", cur_row, cur_col);
        end
        wq.delete();
        send_key(8'h42, acc);
        tests++; if (wq.size() != 1 || wq[0].addr != 239 || wq[0].data !== 16'h0F42) begin
            fails++; $display("FAIL wrap_write: got %0d writes first addr %0d want 1 write to 239 of 0f42",
                              wq.size(), (wq.size() > 0) ? wq[0].addr : -1);
        end
        tests++; if (cur_row !== 5'd3 || cur_col !== 7'd0) begin
            fails++; $display("FAIL wrap_cursor: got (%0d,%0d) want (3,0)", cur_row, cur_col);
        end
    endtask

    task automatic test_backspace();
        int acc;
        send_key(8'h0C, acc);
        tests++; if (cur_row !== 5'd0 || cur_col !== 7'd0) begin
            fails++; $display("FAIL bs_home: got (%0d,%0d) want (0,0)", cur_row, cur_col);
        end
        wq.delete();
        send_key(8'h08, acc);
        tests++; if (wq.size() != 0) begin fails++; $display("FAIL bs_origin_write: got %0d writes want 0", wq.size()); end
        tests++; if (cur_row !== 5'd0 || cur_col !== 7'd0) begin
            fails++; $display("FAIL bs_origin_cursor: got (%0d,%0d) want (0,0)", cur_row, cur_col);
        end
        send_key(8'h0A, acc);
        wq.delete();
        send_key(8'h08, acc);
        tests++; if (wq.size() != 1 || wq[0].addr != 79 || wq[0].data !== 16'h0F20) begin
            fails++; $display("FAIL bs_line_write: got %0d writes first addr %0d want 1 write to 79 of 0f20",
                              wq.size(), (wq.size() > 0) ? wq[0].addr : -1);
        end
        tests++; if (cur_row !== 5'd0 || cur_col !== 7'd79) begin
            fails++; $display("FAIL bs_line_cursor: got (%0d,%0d) want (0,79)", cur_row, cur_col);
        end
    endtask

    task automatic test_busy_ignore();
        int hi = 0;
        int bad = 0;
        wait_ready("busy_pre");
        key_code  = 8'h0C;
        key_valid = 1'b1;
        @(negedge clk);
        key_code = 8'h41;
        for (int i = 0; i < 50; i++) begin
            if (key_ready !== 1'b0) hi++;
            @(negedge clk);
        end
        key_valid = 1'b0;
        wait_ready("busy_post");
        model_key(8'h0C);
        tests++; if (hi != 0) begin fails++; $display("FAIL busy_ready: high %0d cycles want 0", hi); end
        foreach (wq[i]) if (wq[i].data === 16'h0F41 && wq[i].cyc > cyc - 2600) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL busy_key_taken: %0d writes of 0f41 want 0", bad); end
        tests++; if (cur_row !== 5'd0 || cur_col !== 7'd0) begin
            fails++; $display("FAIL busy_cursor: got (%0d,%0d) want (0,0)", cur_row, cur_col);
        end
    endtask

    task automatic test_random();
        int acc;
        int bad = 0;
        int r;
        logic [7:0] k;
        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      k = rand_print();
            else if (r < 84) k = 8'h0A;
            else if (r < 94) k = 8'h08;
            else             k = 8'($urandom_range(32'h80, 32'hFF));
            send_key(k, acc);
            tests++; if (cur_row !== 5'(mrow) || cur_col !== 7'(mcol)) begin
                fails++; $display("FAIL rand_cursor key %h: got (%0d,%0d) want (%0d,%0d)",
                                  k, cur_row, cur_col, mrow, mcol);
            end
        end
        for (int i = 0; i < N; i++) if (tmem[i] !== {8'h0F, mscr[i]}) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL rand_screen: %0d cells differ want 0", bad); end
    endtask

    task automatic test_overflow();
        int acc;
        int lo = 0;
        int bad = 0;
        int bad2 = 0;
        send_key(8'h0C, acc);
        for (int r = 0; r < R - 1; r++) begin
            for (int j = 0, m = int'($urandom_range(1, 10)); j < m; j++) send_key(rand_print(), acc);
            send_key(8'h0A, acc);
        end
        for (int j = 0; j < 5; j++) send_key(rand_print(), acc);
        tests++; if (cur_row !== 5'd29 || cur_col !== 7'd5) begin
            fails++; $display("FAIL ovf_pre_cursor: got (%0d,%0d) want (29,5)", cur_row, cur_col);
        end
        for (int i = 0; i < N; i++) old[i] = mscr[i];
        wq.delete();
        key_code  = 8'h0A;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        while (key_ready !== 1'b1 && lo < 6000) begin
            lo++;
            @(negedge clk);
        end
        model_key(8'h0A);
`ifdef CONSOLE_SCROLL_EN
        tests++; if (lo != 2 * C * (R - 1) + C) begin
            fails++; $display("FAIL scroll_busy_cycles: got %0d want %0d", lo, 2 * C * (R - 1) + C);
        end
        tests++; if (wq.size() != N) begin fails++; $display("FAIL scroll_writes: got %0d want %0d", wq.size(), N); end
        for (int i = 0; i < N - C; i++) if (tmem[i] !== {8'h0F, old[i + C]}) bad++;
        for (int i = N - C; i < N; i++) if (tmem[i] !== 16'h0F20) bad2++;
        tests++; if (bad != 0) begin fails++; $display("FAIL scroll_shift: %0d cells differ want 0", bad); end
        tests++; if (bad2 != 0) begin fails++; $display("FAIL scroll_blank: %0d cells differ want 0", bad2); end
        tests++; if (cur_row !== 5'd29 || cur_col !== 7'd0) begin
            fails++; $display("FAIL scroll_cursor: got (%0d,%0d) want (29,0)", cur_row, cur_col);
        end
`else
        tests++; if (lo != C) begin fails++; $display("FAIL wrap_busy_cycles: got %0d want %0d", lo, C); end
        tests++; if (wq.size() != C) begin fails++; $display("FAIL wrap_writes: got %0d want %0d", wq.size(), C); end
        foreach (wq[i]) if (wq[i].addr != i || wq[i].data !== 16'h0F20) bad++;
        for (int i = C; i < N; i++) if (tmem[i] !== {8'h0F, old[i]}) bad2++;
        tests++; if (bad != 0) begin fails++; $display("FAIL wrap_blank: %0d bad writes want 0", bad); end
        tests++; if (bad2 != 0) begin fails++; $display("FAIL wrap_keep: %0d cells differ want 0", bad2); end
        tests++; if (cur_row !== 5'd0 || cur_col !== 7'd0) begin
            fails++; $display("FAIL wrap_home: got (%0d,%0d) want (0,0)", cur_row, cur_col);
        end
`endif
        bad = 0;
        for (int i = 0; i < N; i++) if (tmem[i] !== {8'h0F, mscr[i]}) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL ovf_screen: %0d cells differ want 0", bad); end
    endtask

    task automatic test_reset_abort();
        int acc;
        int we_hi = 0;
        int bad = 0;
        for (int j = 0; j < 6; j++) send_key(rand_print(), acc);
        key_code  = 8'h0C;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        repeat (100) @(negedge clk);
        rst = 1'b1;
        wq.delete();
        for (int i = 0; i < 5; i++) begin
            #1;
            if (vga_we !== 1'b0) we_hi++;
            @(negedge clk);
        end
        tests++; if (we_hi != 0 || wq.size() != 0) begin
            fails++; $display("FAIL abort_writes: we high %0d, %0d writes want 0", we_hi, wq.size());
        end
        tests++; if (busy !== 1'b1 || key_ready !== 1'b0) begin
            fails++; $display("FAIL abort_status: busy=%b ready=%b want 1/0", busy, key_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        wait_ready("abort_clear");
        model_key(8'h0C);
        tests++; if (wq.size() != N) begin fails++; $display("FAIL abort_clear_count: got %0d want %0d", wq.size(), N); end
        for (int i = 0; i < N; i++) if (tmem[i] !== 16'h0F20) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL abort_blank: %0d cells differ want 0", bad); end
        tests++; if (cur_row !== 5'd0 || cur_col !== 7'd0) begin
            fails++; $display("FAIL abort_cursor: got (%0d,%0d) want (0,0)", cur_row, cur_col);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_put();
        test_wrap();
        test_backspace();
        test_busy_ignore();
        test_random();
        test_overflow();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/keypad_text_console.md
KEYPAD_TEXT_CONSOLE -- requirements
Module: keypad_text_console

Interface
REQ-001 The module SHALL have parameter COLS, default 80, meaning characters per text row.
REQ-002 The module SHALL have parameter ROWS, default 30, meaning text rows on screen.
REQ-003 The module SHALL have parameter ADDR_W, default 12, meaning the VGA address width; COLS*ROWS <= 2**ADDR_W is required.
REQ-004 The module SHALL have parameter ATTR, default 8'h0F, meaning the colour attribute byte written with every cell.
REQ-005 The module SHALL have the port: clk  input  1  system clock, all logic on rising edge.
REQ-006 The module SHALL have the port: rst  input  1  asynchronous, active-high reset.
REQ-007 The module SHALL have the port: key_code  input  8  keypad character code.
REQ-008 The module SHALL have the port: key_valid  input  1  key_code valid.
REQ-009 The module SHALL have the port: key_ready  output  1  console can accept a key.
REQ-010 The module SHALL have the port: vga_addr  output  ADDR_W  text-memory cell address, row*COLS+col.
REQ-011 The module SHALL have the port: vga_we  output  1  text-memory write strobe.
REQ-012 The module SHALL have the port: vga_data  output  16  write data, {ATTR, char}.
REQ-013 The module SHALL have the port: vga_rd  input  16  text-memory read data, valid one cycle after vga_addr is presented.
REQ-014 The module SHALL have the port: cur_col  output  clog2(COLS)  cursor column.
REQ-015 The module SHALL have the port: cur_row  output  clog2(ROWS)  cursor row.
REQ-016 The module SHALL have the port: busy  output  1  multi-cycle operation in progress.

Function
REQ-017 The FSM SHALL have the states IDLE, PUT, CLEAR, SCROLL_RD, SCROLL_WR and BLANK.
REQ-018 key_ready SHALL be high only in IDLE; a key is accepted on a clk edge with key_valid & key_ready, and is ignored otherwise.
REQ-019 For a printable key (0x20-0x7E) accepted in cycle N, the block SHALL drive vga_we=1, vga_addr=cursor and vga_data={ATTR,key} in cycle N+1 (PUT), return to IDLE in N+2, and advance the cursor by one column.
REQ-020 A column advance from COLS-1, or key 0x0A (newline), SHALL set col=0 and row=row+1; the newline itself writes nothing.
REQ-021 A row advance from ROWS-1 SHALL go to SCROLL_RD (with CONSOLE_SCROLL_EN) or to BLANK of row 0 (without).
REQ-022 Key 0x08 (backspace) SHALL move the cursor back one cell (col 0 -> COLS-1 of row-1) and write {ATTR,0x20} at the new cursor; at (0,0) it SHALL make no write and no cursor change.
REQ-023 Key 0x0C SHALL enter CLEAR: write {ATTR,0x20} to addresses 0..COLS*ROWS-1, one per cycle ascending, then cursor=(0,0) and IDLE.
REQ-024 All other codes SHALL be accepted and discarded, with no write.
REQ-025 SCROLL SHALL, for i = 0..COLS*(ROWS-1)-1: in SCROLL_RD present vga_addr=i+COLS with vga_we=0; in SCROLL_WR write vga_rd to address i. It then BLANKs row ROWS-1 (COLS writes of {ATTR,0x20}), leaving cursor=(ROWS-1,0).
REQ-026 BLANK SHALL write COLS spaces to the target row, ascending.
REQ-027 busy SHALL be high in every state except IDLE.
REQ-028 vga_we SHALL be 0 in IDLE and SCROLL_RD.

Reset
REQ-029 While rst=1, outputs SHALL be: vga_we=0, vga_addr=0, vga_data=0, cur_col=0, cur_row=0, key_ready=0, busy=1.
REQ-030 After rst deasserts, the FSM SHALL start in CLEAR, which clears the screen before the first key is accepted.
REQ-031 A reset asserted mid-operation SHALL abort it immediately, with no further writes; the following CLEAR restores a blank screen.

Configuration
REQ-032 With CONSOLE_SCROLL_EN defined, scrolling SHALL be implemented per REQ-025; without it, the SCROLL_RD/SCROLL_WR logic SHALL be absent, vga_rd SHALL be unused, and overflow SHALL wrap to row 0 after blanking it.

Verification
REQ-033 The bench SHALL check: reset release -> exactly COLS*ROWS space writes, addresses 0..2399 (defaults), then key_ready=1 and cursor (0,0).
REQ-034 The bench SHALL check: key 0x41 at cursor (0,0) -> one write, addr 0, data 16'h0F41, one cycle after acceptance; cur_col=1.
REQ-035 The bench SHALL check: with cursor (2,79), key 0x42 -> write to addr 239, then cursor (3,0).
REQ-036 The bench SHALL check: backspace at (0,0) -> no write; backspace at (1,0) -> write 16'h0F20 to addr 79, cursor (0,79).
REQ-037 The bench SHALL check: with CONSOLE_SCROLL_EN, model memory, cursor (29,5), newline -> old row 1 now at row 0, row 29 all 16'h0F20, cursor (29,0), key_ready low throughout.
REQ-038 The bench SHALL check: without CONSOLE_SCROLL_EN, the same stimulus -> addresses 0..79 written with 16'h0F20, rows 1-29 unchanged, cursor (0,0).
